// File: rtl/am2901_useq.sv
// am2901_useq: microprogram sequencer driving an Am2901 slice from a loadable 64-word store.
// Define AM2901_USEQ_STACK_EN to build in the CALL/RET return stack of STACK_DEPTH entries.
module am2901_useq #(
  parameter int UADDR_W     = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic               cp,
  input  logic               rst,
  input  logic               start,
  input  logic [UADDR_W-1:0] start_addr,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               ucode_we,
  input  logic [UADDR_W-1:0] ucode_waddr,
  input  logic [31:0]        ucode_wdata,
  output logic [8:0]         i,
  output logic [3:0]         a,
  output logic [3:0]         b,
  output logic [3:0]         d,
  output logic               cin,
  input  logic               z,
  input  logic               cout,
  input  logic               ovr,
  input  logic               f3
);

  localparam int WORDS = 1 << UADDR_W;

  typedef enum logic [3:0] {
    OP_CONT  = 4'd0,
    OP_JMP   = 4'd1,
    OP_JZ    = 4'd2,
    OP_JNZ   = 4'd3,
    OP_JC    = 4'd4,
    OP_JOVR  = 4'd5,
    OP_CALL  = 4'd6,
    OP_RET   = 4'd7,
    OP_LDCNT = 4'd8,
    OP_RPT   = 4'd9,
    OP_HALT  = 4'd10
  } seqop_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state;
  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] next_upc;
  logic [UADDR_W-1:0] tgt_addr;
  logic [5:0]         cnt;
  logic [31:0]        mem [WORDS];
  logic [31:0]        word;
  seqop_e             seqop;
  logic [5:0]         tgt;
  logic               stop;
  logic               fault;
  logic               cnt_load;
  logic               cnt_dec;
  logic               push;
  logic               pop;
  logic               unused_ok;

  assign word     = mem[upc];
  assign seqop    = seqop_e'(word[25:22]);
  assign tgt      = word[31:26];
  assign tgt_addr = UADDR_W'(tgt);
  assign upc_inc  = upc + 1'b1;
  assign busy     = (state == S_RUN);

`ifdef AM2901_USEQ_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [UADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]    sp;
  logic [SP_W-1:0]    sp_dec;
  logic               stack_full;
  logic               stack_empty;

  assign sp_dec      = sp - 1'b1;
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign unused_ok   = f3;

  // NOTE: storage arrays (stack, microcode) carry no reset; only the pointers that qualify them do.
  always_ff @(posedge cp) begin
    if (state == S_RUN && push) stack[sp[IDX_W-1:0]] <= upc_inc;
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (state == S_IDLE) begin
      if (start) sp <= '0;
    end else if (!stop && !fault) begin
      if (push)     sp <= sp + 1'b1;
      else if (pop) sp <= sp_dec;
    end
  end
`else
  // Depth only matters when the stack is compiled in; f3 selects no branch.
  assign unused_ok = f3 & (STACK_DEPTH > 0);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    next_upc = upc_inc;
    stop     = 1'b0;
    fault    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (seqop)
      OP_JMP:  next_upc = tgt_addr;
      OP_JZ:   if (z)    next_upc = tgt_addr;
      OP_JNZ:  if (!z)   next_upc = tgt_addr;
      OP_JC:   if (cout) next_upc = tgt_addr;
      OP_JOVR: if (ovr)  next_upc = tgt_addr;
`ifdef AM2901_USEQ_STACK_EN
      OP_CALL: begin
        if (stack_full) begin
          fault = 1'b1;
        end else begin
          push     = 1'b1;
          next_upc = tgt_addr;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          fault = 1'b1;
        end else begin
          pop      = 1'b1;
          next_upc = stack[sp_dec[IDX_W-1:0]];
        end
      end
`else
      OP_CALL: fault = 1'b1;
      OP_RET:  fault = 1'b1;
`endif
      OP_LDCNT: cnt_load = 1'b1;
      OP_RPT: begin
        if (cnt != '0) begin
          cnt_dec  = 1'b1;
          next_upc = tgt_addr;
        end
      end
      OP_HALT: stop = 1'b1;
      default: ;
    endcase
  end

  // IDLE presents a word that cannot disturb the slice's registers.
  always_comb begin
    if (state == S_RUN) begin
      i   = word[8:0];
      a   = word[12:9];
      b   = word[16:13];
      d   = word[20:17];
      cin = word[21];
    end else begin
      i   = 9'h040;
      a   = '0;
      b   = '0;
      d   = '0;
      cin = 1'b0;
    end
  end

  always_ff @(posedge cp) begin
    if (ucode_we && state == S_IDLE) mem[ucode_waddr] <= ucode_wdata;
  end

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      upc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            upc   <= start_addr;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop || fault) begin
            state <= S_IDLE;
            done  <= 1'b1;
            if (fault) err <= 1'b1;
          end else begin
            upc <= next_upc;
            if (cnt_load)     cnt <= tgt;
            else if (cnt_dec) cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am2901_useq.sv
// Self-checking bench for am2901_useq: an instruction-level interpreter predicts each run's issued trace.
module tb_am2901_useq;

  logic        cp = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  start_addr;
  logic        busy, done, err;
  logic        ucode_we;
  logic [5:0]  ucode_waddr;
  logic [31:0] ucode_wdata;
  logic [8:0]  i;
  logic [3:0]  a, b, d;
  logic        cin;
  logic        z, cout, ovr, f3;

  am2901_useq dut (
    .cp(cp), .rst(rst), .start(start), .start_addr(start_addr),
    .busy(busy), .done(done), .err(err),
    .ucode_we(ucode_we), .ucode_waddr(ucode_waddr), .ucode_wdata(ucode_wdata),
    .i(i), .a(a), .b(b), .d(d), .cin(cin),
    .z(z), .cout(cout), .ovr(ovr), .f3(f3)
  );

  always #5 cp = ~cp;

`ifdef AM2901_USEQ_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Microword builder: op, target and a 9-bit tag that also seeds the other fields.
  function automatic logic [31:0] mk(input int op, input int tg, input int tag);
    logic [31:0] w;
    w = '0;
    w[31:26] = tg[5:0];
    w[25:22] = op[3:0];
    w[21]    = tag[0];
    w[20:17] = tag[3:0];
    w[16:13] = tag[7:4];
    w[12:9]  = tag[3:0] ^ 4'h5;
    w[8:0]   = tag[8:0];
    return w;
  endfunction

  // Reference model: the microcode image and an interpreter that yields the issued trace.
  logic [31:0] umem [64];
  logic [31:0] trace [$];
  logic        exp_err;

  task automatic interpret(input int pc0, input logic fz, input logic fc, input logic fv);
    int pc, nxt, op, tg, cnt;
    int stk [$];
    logic [31:0] w;
    trace.delete();
    exp_err = 1'b0;
    pc = pc0;
    cnt = 0;
    for (int steps = 0; steps < 300; steps++) begin
      w = umem[pc];
      trace.push_back(w);
      op  = int'(w[25:22]);
      tg  = int'(w[31:26]);
      nxt = (pc + 1) % 64;
      case (op)
        1: nxt = tg;
        2: if (fz)  nxt = tg;
        3: if (!fz) nxt = tg;
        4: if (fc)  nxt = tg;
        5: if (fv)  nxt = tg;
        6: begin
          if (!STACK || stk.size() == 4) begin exp_err = 1'b1; return; end
          stk.push_back(nxt);
          nxt = tg;
        end
        7: begin
          if (!STACK || stk.size() == 0) begin exp_err = 1'b1; return; end
          nxt = stk.pop_back();
        end
        8: cnt = tg;
        9: if (cnt > 0) begin cnt--; nxt = tg; end
        10: return;
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  typedef struct {
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] w;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;
  int   busy_cycles = 0;
  int   last_busy;

  // Single compare process: one expectation per falling edge while a run is scheduled.
  always @(negedge cp) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (busy === 1'b1) busy_cycles++;
      check("busy", busy, cur.busy);
      check("done", done, cur.done);
      check("err", err, cur.err);
      if (cur.busy) begin
        check("i", i, cur.w[8:0]);
        check("abdcin", {a, b, d, cin}, {cur.w[12:9], cur.w[16:13], cur.w[20:17], cur.w[21]});
      end else begin
        check("i_safe", i, 9'h040);
        check("abdcin_safe", {a, b, d, cin}, 13'h0);
      end
    end
  end

  task automatic wr(input int ad, input logic [31:0] w);
    @(negedge cp);
    ucode_we = 1'b1; ucode_waddr = ad[5:0]; ucode_wdata = w;
    @(posedge cp); #1;
    ucode_we = 1'b0;
    umem[ad] = w;
  endtask

  // Runs one program; wa >= 0 writes wd to wa on the same edge that accepts start.
  task automatic exec(input int sa, input logic fz, input logic fc, input logic fv,
                      input bit noise, input int wa, input logic [31:0] wd);
    exp_t e;
    int guard, b0;
    if (wa >= 0) umem[wa] = wd;
    interpret(sa, fz, fc, fv);
    @(negedge cp);
    z = fz; cout = fc; ovr = fv;
    start = 1'b1; start_addr = sa[5:0];
    if (wa >= 0) begin ucode_we = 1'b1; ucode_waddr = wa[5:0]; ucode_wdata = wd; end
    @(posedge cp); #1;
    start = 1'b0; ucode_we = 1'b0;
    b0 = busy_cycles;
    foreach (trace[k]) begin
      e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.w = trace[k];
      exp_q.push_back(e);
    end
    e.busy = 1'b0; e.done = 1'b1; e.err = exp_err; e.w = '0;
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
    if (noise) begin
      @(negedge cp); start = 1'b1; start_addr = 6'd63;
      @(posedge cp); #1; start = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      @(posedge cp);
      guard++;
    end
    if (exp_q.size() > 0) begin
      check("run_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    last_busy = busy_cycles - b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n5;
    rst = 1'b1; start = 1'b0; start_addr = '0;
    ucode_we = 1'b0; ucode_waddr = '0; ucode_wdata = '0;
    z = 1'b0; cout = 1'b0; ovr = 1'b0; f3 = 1'b0;

    @(posedge cp); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_i", i, 9'h040);
    check("rst_abdcin", {a, b, d, cin}, 13'h0);
    @(negedge cp); rst = 1'b0;

    // Straight line; word 1 uses reserved op 13, which must behave as CONT.
    wr(0, mk(0, 0, 'h101));
    wr(1, mk(13, 0, 'h0A2));
    wr(2, mk(10, 0, 'h1C3));
    exec(0, 0, 0, 0, 1, -1, '0);
    check("straight_len", trace.size(), 3);
    check("straight_busy", last_busy, 3);

    // Loop: LDCNT 2 then RPT back onto itself.
    wr(4, mk(8, 2, 'h014));
    wr(5, mk(9, 5, 'h025));
    wr(6, mk(10, 0, 'h036));
    exec(4, 0, 0, 0, 0, -1, '0);
    n5 = 0;
    foreach (trace[k]) if (trace[k] == umem[5]) n5++;
    check("loop_len", trace.size(), 5);
    check("loop_rpt_count", n5, 3);
    check("loop_busy", last_busy, 5);

    // Conditional branches, taken and not taken.
    wr(9, mk(10, 0, 'h1F9));
    wr(0, mk(2, 9, 'h0F0));
    exec(0, 1, 0, 0, 0, -1, '0);
    check("jz_taken_busy", last_busy, 2);
    exec(0, 0, 0, 0, 0, -1, '0);
    check("jz_not_busy", last_busy, 3);
    wr(0, mk(4, 9, 'h0E1));
    exec(0, 0, 1, 0, 0, -1, '0);
    exec(0, 1, 0, 1, 0, -1, '0);
    wr(0, mk(5, 9, 'h0D2));
    exec(0, 0, 0, 1, 0, -1, '0);
    exec(0, 1, 1, 0, 0, -1, '0);
    wr(0, mk(3, 9, 'h0C3));
    exec(0, 0, 0, 0, 0, -1, '0);
    check("jnz_taken_busy", last_busy, 2);

    // Address wrap 63 -> 0.
    wr(63, mk(0, 0, 'h063));
    wr(0, mk(0, 0, 'h101));
    exec(63, 0, 0, 0, 0, -1, '0);
    check("wrap_busy", last_busy, 4);

    // Write and start on the same edge: new word must be the first issued.
    exec(30, 0, 0, 0, 0, 30, mk(10, 0, 'h130));
    check("wr_start_busy", last_busy, 1);

    // Nested subroutines, four deep.
    wr(32, mk(6, 40, 'h120)); wr(33, mk(10, 0, 'h121));
    wr(40, mk(6, 44, 'h140)); wr(41, mk(7, 0, 'h141));
    wr(44, mk(6, 48, 'h144)); wr(45, mk(7, 0, 'h145));
    wr(48, mk(6, 52, 'h148)); wr(49, mk(7, 0, 'h149));
    wr(52, mk(7, 0, 'h152));
    exec(32, 0, 0, 0, 0, -1, '0);
    if (STACK) begin
      check("call4_busy", last_busy, 9);
      wr(52, mk(6, 56, 'h152)); wr(56, mk(10, 0, 'h156));
      exec(32, 0, 0, 0, 0, -1, '0);
      check("call5_busy", last_busy, 5);
      check("call5_err", err, 1'b1);
      wr(60, mk(7, 0, 'h160));
      exec(60, 0, 0, 0, 0, -1, '0);
      check("ret_empty_err", err, 1'b1);
    end else begin
      check("call_nostack_busy", last_busy, 1);
      check("call_nostack_err", err, 1'b1);
    end

    // Reset mid-run plus write guard; err is still set from the error run above.
    wr(16, mk(0, 0, 'h016)); wr(17, mk(0, 0, 'h017)); wr(18, mk(0, 0, 'h018));
    wr(19, mk(0, 0, 'h019)); wr(20, mk(10, 0, 'h020));
    @(negedge cp); start = 1'b1; start_addr = 6'd16;
    @(posedge cp); #1; start = 1'b0;
    @(negedge cp); ucode_we = 1'b1; ucode_waddr = 6'd18; ucode_wdata = 32'hDEAD_BEEF;
    @(posedge cp); #1; ucode_we = 1'b0;
    check("mid_busy", busy, 1'b1);
    check("mid_i", i, 9'h017);
    #2; rst = 1'b1; #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_err", err, 1'b0);
    check("async_rst_i", i, 9'h040);
    @(negedge cp); rst = 1'b0;
    repeat (3) begin
      @(negedge cp);
      check("no_done_after_rst", done, 1'b0);
    end
    exec(16, 0, 0, 0, 0, -1, '0);
    check("replay_busy", last_busy, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
